debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000: clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter STABLE_TICKS, default 5: consecutive ticks of a differing input needed to flip the debounced level (>=1).
REQ-004 SHALL have parameter LONG_TICKS, default 500: ticks of held press before the long-press pulse (>STABLE_TICKS).
REQ-005 SHALL have parameter REPEAT_TICKS, default 100: ticks between auto-repeat pulses (>=1).
REQ-006 SHALL have parameter ACTIVE_LOW, default 0: 1 inverts raw inputs after synchronisation.
REQ-007 SHALL have port clk, input, 1: sole clock; all state is updated on its rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port btn_raw, input, N_CH: asynchronous, bouncing button inputs.
REQ-010 SHALL have port repeat_en, input, 1: enables auto-repeat after a long press.
REQ-011 SHALL have port btn_level, output, N_CH: debounced level, 1 = pressed.
REQ-012 SHALL have port press_p, output, N_CH: one-cycle pulse on a debounced rising edge.
REQ-013 SHALL have port release_p, output, N_CH: one-cycle pulse on a debounced falling edge.
REQ-014 SHALL have port long_p, output, N_CH: one-cycle pulse when LONG_TICKS of hold is reached.
REQ-015 SHALL have port repeat_p, output, N_CH: one-cycle auto-repeat pulse.

Function
REQ-016 SHALL pass each btn_raw bit through a 2-flop synchroniser, then apply the ACTIVE_LOW inversion, giving s[i].
REQ-017 SHALL run one shared prescaler counting 0..TICK_DIV-1 that asserts tick for one cycle when the count equals TICK_DIV-1, then wraps to 0.
REQ-018 SHALL clear stable counter cnt[i] to 0 on any cycle where s[i]==btn_level[i].
REQ-019 SHALL, on a tick cycle with s[i]!=btn_level[i], increment cnt[i]; when the incremented value equals STABLE_TICKS, set btn_level[i]<=s[i] and clear cnt[i].
REQ-020 SHALL assert press_p[i] (or release_p[i]) in exactly the first cycle in which btn_level[i] shows the new value 1 (or 0).
REQ-021 SHALL implement a per-channel FSM with states IDLE, HELD, LONG: IDLE->HELD on debounced rise; HELD->LONG when hold_cnt reaches LONG_TICKS; HELD or LONG->IDLE on debounced fall.
REQ-022 SHALL clear hold_cnt on entry to HELD and increment it on each tick in HELD; long_p[i] SHALL pulse in the cycle of the HELD->LONG transition.
REQ-023 SHALL, in LONG with repeat_en=1, count ticks and pulse repeat_p[i] every REPEAT_TICKS ticks, the first pulse occurring REPEAT_TICKS ticks after long_p; with repeat_en=0 the repeat counter SHALL hold at 0.
REQ-024 SHALL produce no long_p or repeat_p when release occurs before LONG_TICKS; a release in the same cycle as the threshold SHALL take priority (go to IDLE, no long_p).
REQ-025 SHALL size every counter with $clog2 of its maximum count so no counter wraps before its threshold.
REQ-026 SHALL process channels fully independently; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-027 SHALL delay a clean input change to btn_level by between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles.

Reset
REQ-028 SHALL, while rst=1, clear synchronisers, prescaler, all counters and all outputs to 0, and set every FSM to IDLE; no pulse SHALL be emitted during or in the cycle after reset.
REQ-029 SHALL treat a button held across reset deassertion as a fresh press, producing press_p after normal debounce latency.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE, HELD, LONG) in the shared package debounce_pkg.
REQ-031 SHALL implement one channel (stable counter, FSM, hold/repeat counters, pulses) as sub-module debounce_chan, instantiated N_CH times by a generate loop; synchroniser and prescaler remain in debounce_bank.

Verification (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2, N_CH=4)
REQ-032 SHALL test that btn_raw[0] toggling every 4 cycles for 40 cycles -> btn_level[0] stays 0 and press_p is never asserted.
REQ-033 SHALL test that btn_raw[1] held at 1 for 60 cycles then released -> btn_level[1] rises within 14 cycles with exactly one press_p, then falls within 14 cycles of release with exactly one release_p.
REQ-034 SHALL test that btn_raw[2] held for 60 ticks with repeat_en=1 -> long_p exactly 8 ticks after press_p, then repeat_p every 8 cycles until release.
REQ-035 SHALL test that btn_raw[3] held for 5 ticks after press_p then released -> no long_p or repeat_p.
REQ-036 SHALL test that rst is asserted for 1 cycle while channel 1 is in LONG -> all outputs are 0 the next cycle, and with the button still held a new press_p follows after debounce latency.
REQ-037 SHALL test that all four channels are pressed in the same cycle -> four press_p bits assert in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce bank: per-channel FSM encoding
// and counter sizing.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } chan_state_e;

  // Bits needed to hold values 0..max_count without wrapping.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button channel: stable counter, press/hold FSM,
// long-press and auto-repeat pulse generation.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 5,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic tick,
  input  logic repeat_en,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p
);

  localparam int unsigned SW = cnt_width(STABLE_TICKS);
  localparam int unsigned HW = cnt_width(LONG_TICKS);
  localparam int unsigned RW = cnt_width(REPEAT_TICKS);

  chan_state_e   state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          level_d, press_d, release_d, long_d, repeat_d;
  logic          rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      level     <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      level     <= level_d;
      press_p   <= press_d;
      release_p <= release_d;
      long_p    <= long_d;
      repeat_p  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    level_d   = level;
    rise      = 1'b0;
    fall      = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    // Debounce: any agreeing cycle restarts the run of differing ticks.
    if (s == level) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q + SW'(1) == SW'(STABLE_TICKS)) begin
        level_d = s;
        cnt_d   = '0;
        rise    = s;
        fall    = ~s;
      end else begin
        cnt_d = cnt_q + SW'(1);
      end
    end

    press_d   = rise;
    release_d = fall;

    // A release on the threshold tick wins over the long-press transition.
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HELD;
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (hold_q + HW'(1) == HW'(LONG_TICKS)) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
        end else if (!repeat_en) begin
          rep_d = '0;
        end else if (tick) begin
          if (rep_q + RW'(1) == RW'(REPEAT_TICKS)) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent button debouncers sharing one input synchroniser
// stage and one sample-tick prescaler.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE_TICKS = 5,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  input  logic            repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_p,
  output logic [N_CH-1:0] repeat_p
);

  localparam int unsigned PW = cnt_width(TICK_DIV - 1);

  logic [N_CH-1:0] sync1_q, sync2_q, s;
  logic [PW-1:0]   presc_q;
  logic            tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign s    = sync2_q ^ {N_CH{ACTIVE_LOW}};

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s        (s[i]),
      .tick     (tick),
      .repeat_en(repeat_en),
      .level    (btn_level[i]),
      .press_p  (press_p[i]),
      .release_p(release_p[i]),
      .long_p   (long_p[i]),
      .repeat_p (repeat_p[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a cycle-level
// behavioural model derived from the debounce/hold/repeat rules.
module tb_debounce_bank;

  localparam int N_CH         = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int LONG_TICKS   = 8;
  localparam int REPEAT_TICKS = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn_raw;
  logic            repeat_en;
  logic [N_CH-1:0] btn_level, press_p, release_p, long_p, repeat_p;

  always #5 clk = ~clk;

  debounce_bank #(
    .N_CH        (N_CH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .press_p  (press_p),
    .release_p(release_p),
    .long_p   (long_p),
    .repeat_p (repeat_p)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Reference model: input delay line, cycles since reset, per-channel tallies.
  logic [N_CH-1:0] m_hist [2];
  int              m_cyc;
  int              m_scnt [N_CH];
  int              m_hold [N_CH];
  int              m_rep  [N_CH];
  logic [N_CH-1:0] m_lvl, m_pr, m_rl, m_lp, m_rp;

  int              pr_cnt [N_CH];
  int              rl_cnt [N_CH];
  int              lp_cnt [N_CH];
  int              rp_cnt [N_CH];
  logic [N_CH-1:0] lvl_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_step();
    logic            tk;
    logic [N_CH-1:0] s;
    logic            was_pressed, fell;
    m_pr = '0; m_rl = '0; m_lp = '0; m_rp = '0;
    if (rst) begin
      m_hist[0] = '0; m_hist[1] = '0; m_cyc = 0; m_lvl = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        m_scnt[ch] = 0; m_hold[ch] = 0; m_rep[ch] = 0;
      end
      return;
    end
    tk = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    m_cyc++;
    s = m_hist[1];
    for (int ch = 0; ch < N_CH; ch++) begin
      was_pressed = m_lvl[ch];
      fell        = 1'b0;
      if (s[ch] == m_lvl[ch]) begin
        m_scnt[ch] = 0;
      end else if (tk) begin
        m_scnt[ch]++;
        if (m_scnt[ch] == STABLE_TICKS) begin
          m_scnt[ch] = 0;
          m_lvl[ch]  = s[ch];
          if (s[ch]) begin
            m_pr[ch] = 1'b1; m_hold[ch] = 0; m_rep[ch] = 0;
          end else begin
            m_rl[ch] = 1'b1; fell = 1'b1;
          end
        end
      end
      // Ticks of hold since the press decide long and repeat pulses.
      if (was_pressed && !fell) begin
        if (m_hold[ch] >= LONG_TICKS) begin
          if (!repeat_en) m_rep[ch] = 0;
          else if (tk) begin
            m_rep[ch]++;
            if (m_rep[ch] == REPEAT_TICKS) begin
              m_rp[ch] = 1'b1; m_rep[ch] = 0;
            end
          end
        end else if (tk) begin
          m_hold[ch]++;
          if (m_hold[ch] == LONG_TICKS) begin
            m_lp[ch] = 1'b1; m_rep[ch] = 0;
          end
        end
      end
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = btn_raw;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    check("btn_level", 32'(btn_level), 32'(m_lvl));
    check("press_p",   32'(press_p),   32'(m_pr));
    check("release_p", 32'(release_p), 32'(m_rl));
    check("long_p",    32'(long_p),    32'(m_lp));
    check("repeat_p",  32'(repeat_p),  32'(m_rp));
    lvl_seen |= btn_level;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (press_p[ch])   pr_cnt[ch]++;
      if (release_p[ch]) rl_cnt[ch]++;
      if (long_p[ch])    lp_cnt[ch]++;
      if (repeat_p[ch])  rp_cnt[ch]++;
    end
  endtask

  task automatic clear_counts();
    lvl_seen = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      pr_cnt[ch] = 0; rl_cnt[ch] = 0; lp_cnt[ch] = 0; rp_cnt[ch] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_counts();
  endtask

  // kind: 0 level high, 1 press pulse, 2 long pulse, 3 level low. lat=-1 on timeout.
  task automatic wait_for(input int ch, input int kind, input int limit, output int lat);
    logic v;
    lat = 0;
    while (lat < limit) begin
      step();
      lat++;
      case (kind)
        0:       v = btn_level[ch];
        1:       v = press_p[ch];
        2:       v = long_p[ch];
        default: v = ~btn_level[ch];
      endcase
      if (v) return;
    end
    lat = -1;
  endtask

  initial begin
    int lat, pcyc, lcyc, prev, rate;
    rst = 1'b1; btn_raw = '0; repeat_en = 1'b0;
    do_reset();
    check("reset_outputs", 32'({btn_level, press_p, release_p, long_p, repeat_p}), 32'(0));

    // Bouncing input never settles long enough to register.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) btn_raw[0] = ~btn_raw[0];
      step();
    end
    btn_raw[0] = 1'b0;
    repeat (16) step();
    check("bounce_press_cnt", 32'(pr_cnt[0]), 32'(0));
    check("bounce_level_seen", 32'(lvl_seen[0]), 32'(0));

    // Clean press and release with latency bounds.
    do_reset();
    btn_raw[1] = 1'b1;
    wait_for(1, 0, 20, lat);
    check("rise_latency_ok", 32'(lat >= 11 && lat <= 14), 32'(1));
    repeat (60 - lat) step();
    btn_raw[1] = 1'b0;
    wait_for(1, 3, 20, lat);
    check("fall_latency_ok", 32'(lat >= 11 && lat <= 14), 32'(1));
    repeat (10) step();
    check("clean_press_cnt", 32'(pr_cnt[1]), 32'(1));
    check("clean_release_cnt", 32'(rl_cnt[1]), 32'(1));

    // Long press followed by auto-repeat.
    do_reset();
    repeat_en = 1'b1;
    btn_raw[2] = 1'b1;
    wait_for(2, 1, 20, lat);
    check("long_press_seen", 32'(lat > 0), 32'(1));
    pcyc = cyc_n; lcyc = 0; prev = 0;
    repeat (60 * TICK_DIV) begin
      step();
      if (long_p[2]) begin
        lcyc = cyc_n; prev = cyc_n;
      end
      if (repeat_p[2]) begin
        check("repeat_gap", 32'(cyc_n - prev), 32'(REPEAT_TICKS * TICK_DIV));
        prev = cyc_n;
      end
    end
    check("long_delay", 32'(lcyc - pcyc), 32'(LONG_TICKS * TICK_DIV));
    check("long_cnt", 32'(lp_cnt[2]), 32'(1));
    check("repeat_cnt", 32'(rp_cnt[2]), 32'(26));
    btn_raw[2] = 1'b0;
    repeat (20) step();

    // Short hold: release lands on the long threshold tick and wins.
    do_reset();
    btn_raw[3] = 1'b1;
    wait_for(3, 1, 20, lat);
    repeat (5 * TICK_DIV) step();
    btn_raw[3] = 1'b0;
    repeat (30) step();
    check("short_long_cnt", 32'(lp_cnt[3]), 32'(0));
    check("short_repeat_cnt", 32'(rp_cnt[3]), 32'(0));
    check("short_release_cnt", 32'(rl_cnt[3]), 32'(1));

    // Reset while in LONG, button still held.
    do_reset();
    btn_raw[1] = 1'b1;
    wait_for(1, 2, 80, lat);
    check("pre_rst_long_seen", 32'(lat > 0), 32'(1));
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_outputs", 32'({btn_level, press_p, release_p, long_p, repeat_p}), 32'(0));
    rst = 1'b0;
    step();
    check("post_rst_pulses", 32'({press_p, release_p, long_p, repeat_p}), 32'(0));
    clear_counts();
    wait_for(1, 1, 20, lat);
    check("re_press_latency_ok", 32'(lat >= 10 && lat <= 13), 32'(1));
    btn_raw = '0;
    repeat (20) step();

    // Simultaneous presses on all channels.
    do_reset();
    btn_raw = '1;
    wait_for(0, 1, 20, lat);
    check("press_all", 32'(press_p), 32'({N_CH{1'b1}}));
    btn_raw = '0;
    repeat (20) step();

    // Randomised segments with varying bounce rates and occasional reset.
    do_reset();
    for (int seg = 0; seg < 10; seg++) begin
      case ($urandom_range(0, 2))
        0:       rate = 3;
        1:       rate = 20;
        default: rate = 60;
      endcase
      repeat_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        for (int ch = 0; ch < N_CH; ch++)
          if ($urandom_range(0, rate) == 0) btn_raw[ch] = ~btn_raw[ch];
        if ($urandom_range(0, 63) == 0) repeat_en = ~repeat_en;
        rst = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
